// File: rtl/lfsr_seed_sequencer_pkg.sv
// lfsr_seed_sequencer_pkg: shared widths, seed default and FSM encoding for the LFSR seed sequencer
package lfsr_seed_sequencer_pkg;
    localparam int RNDSIZE = 8;
    localparam int W = RNDSIZE * (RNDSIZE - 1) / 2;
    localparam logic [W-1:0] SEED_DEFAULT = W'(28'h000_ACE1);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // An all-zero seed would lock the LFSR, so it is replaced by the default
    function automatic logic [W-1:0] seed_or_default(input logic [W-1:0] s);
        return (s == '0) ? SEED_DEFAULT : s;
    endfunction
endpackage

// File: rtl/lfsr_seed_sequencer_if.sv
// lfsr_seed_sequencer_if: valid/ready frame channel carrying one rnd word and its index
interface lfsr_seed_sequencer_if;
    import lfsr_seed_sequencer_pkg::*;
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic [7:0]   idx;
    modport master(output valid, data, idx, input ready);
    modport slave(input valid, data, idx, output ready);
endinterface

// File: rtl/lfsr_seed_sequencer_frame_out_reg.sv
// frame_out_reg: single-entry valid/ready output register holding data and index
module frame_out_reg
    import lfsr_seed_sequencer_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic [7:0]                   push_idx,
    output logic                         accept,
    lfsr_seed_sequencer_if.master        out
);
    assign accept = !out.valid || out.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out.valid <= 1'b0;
            out.data  <= '0;
            out.idx   <= '0;
        end else if (push && accept) begin
            out.valid <= 1'b1;
            out.data  <= push_data;
            out.idx   <= push_idx;
        end else if (out.ready) begin
            out.valid <= 1'b0;
        end
    end
endmodule

// File: rtl/lfsr_seed_sequencer.sv
// lfsr_seed_sequencer: owns the LFSR seed, feeds rnd back as next seed and streams one word per frame
module lfsr_seed_sequencer
    import lfsr_seed_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          seed_in,
    input  logic                  seed_load,
    input  logic                  start,
    input  logic [7:0]            num_frames,
    input  logic [1:0]            probability_in,
    output logic [W-1:0]          seed,
    output logic [1:0]            probability,
    input  logic [W-1:0]          rnd_in,
    lfsr_seed_sequencer_if.master frame,
    output logic                  busy,
    output logic                  done
);
    logic [1:0] state;
    logic [7:0] nf;
    logic [7:0] cnt;
    logic       run;
    logic       accept;
    logic       step;

    assign run  = state == ST_RUN;
    assign step = run && accept;
    assign busy = run || state == ST_DRAIN;

    frame_out_reg u_out (
        .clk       (clk),
        .rst       (rst),
        .push      (run),
        .push_data (rnd_in),
        .push_idx  (cnt),
        .accept    (accept),
        .out       (frame)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            seed        <= SEED_DEFAULT;
            probability <= '0;
            nf          <= '0;
            cnt         <= '0;
            done        <= 1'b0;
        end else begin
            done <= state == ST_DONE;
            if (state == ST_IDLE) begin
                if (seed_load)
                    seed <= seed_or_default(seed_in);
                if (start) begin
                    nf          <= num_frames;
                    probability <= probability_in;
                    cnt         <= '0;
                    state       <= (num_frames == '0) ? ST_DONE : ST_RUN;
                end
            end else if (step) begin
                seed <= rnd_in;
                cnt  <= cnt + 8'd1;
                // equality compare: cnt stops at nf, so 255 frames never wrap
                if (cnt + 8'd1 == nf)
                    state <= ST_DRAIN;
            end else if (state == ST_DRAIN && frame.ready) begin
                state <= ST_DONE;
            end else if (state == ST_DONE) begin
                state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_lfsr_seed_sequencer.sv
// tb_lfsr_seed_sequencer: directed table-driven bench with an rnd = seed+1 comb-stage stub
module tb_lfsr_seed_sequencer;
    import lfsr_seed_sequencer_pkg::*;

    logic         clk;
    logic         rst;
    logic [W-1:0] seed_in;
    logic         seed_load;
    logic         start;
    logic [7:0]   num_frames;
    logic [1:0]   probability_in;
    logic [W-1:0] seed;
    logic [1:0]   probability;
    logic [W-1:0] rnd_in;
    logic         busy;
    logic         done;
    int           checks;
    int           failures;

    lfsr_seed_sequencer_if fif ();

    assign rnd_in = seed + W'(1);

    lfsr_seed_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .seed_in        (seed_in),
        .seed_load      (seed_load),
        .start          (start),
        .num_frames     (num_frames),
        .probability_in (probability_in),
        .seed           (seed),
        .probability    (probability),
        .rnd_in         (rnd_in),
        .frame          (fif),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         load;
        logic [W-1:0] sin;
        logic [7:0]   nf;
        logic [1:0]   prob;
        logic [31:0]  exp_first;
        logic [31:0]  exp_end;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic begin_run(input logic ld, input logic [W-1:0] s, input logic [7:0] n, input logic [1:0] p);
        seed_load      = ld;
        seed_in        = s;
        start          = 1'b1;
        num_frames     = n;
        probability_in = p;
        tick();
        seed_load      = 1'b0;
        start          = 1'b0;
        probability_in = ~p;
    endtask

    initial begin
        clk = 0; rst = 1; seed_in = '0; seed_load = 0; start = 0;
        num_frames = 0; probability_in = 0; fif.ready = 1;
        checks = 0; failures = 0;
        vecs[0] = '{1'b1, 28'h5,       8'd3,   2'd1, 32'h6,    32'h8};
        vecs[1] = '{1'b0, 28'h0,       8'd2,   2'd2, 32'h9,    32'hA};
        vecs[2] = '{1'b1, 28'h0,       8'd1,   2'd3, 32'hACE2, 32'hACE2};
        vecs[3] = '{1'b1, 28'hFFFFFFF, 8'd2,   2'd0, 32'h0,    32'h1};
        vecs[4] = '{1'b0, 28'h0,       8'd255, 2'd1, 32'h2,    32'h100};
        #2;
        chk("rst_seed",  32'(seed), 32'hACE1);
        chk("rst_prob",  32'(probability), 0);
        chk("rst_valid", 32'(fif.valid), 0);
        chk("rst_data",  32'(fif.data), 0);
        chk("rst_idx",   32'(fif.idx), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        @(posedge clk);
        #3 rst = 0;
        tick();

        for (int v = 0; v < 5; v++) begin
            begin_run(vecs[v].load, vecs[v].sin, vecs[v].nf, vecs[v].prob);
            chk($sformatf("v%0d_busy", v), 32'(busy), 1);
            chk($sformatf("v%0d_prob", v), 32'(probability), 32'(vecs[v].prob));
            chk($sformatf("v%0d_valid0", v), 32'(fif.valid), 0);
            for (int i = 0; i < int'(vecs[v].nf); i++) begin
                tick();
                chk($sformatf("v%0d_valid_%0d", v, i), 32'(fif.valid), 1);
                chk($sformatf("v%0d_data_%0d", v, i), 32'(fif.data), vecs[v].exp_first + 32'(i));
                chk($sformatf("v%0d_idx_%0d", v, i), 32'(fif.idx), 32'(i));
            end
            tick();
            chk($sformatf("v%0d_drained", v), 32'(fif.valid), 0);
            chk($sformatf("v%0d_early_done", v), 32'(done), 0);
            chk($sformatf("v%0d_idle_busy", v), 32'(busy), 0);
            tick();
            chk($sformatf("v%0d_done", v), 32'(done), 1);
            tick();
            chk($sformatf("v%0d_done_pulse", v), 32'(done), 0);
            chk($sformatf("v%0d_seed_end", v), 32'(seed), vecs[v].exp_end);
        end

        // backpressure: first frame held four cycles, then the sequence resumes
        begin_run(1'b1, 28'h5, 8'd3, 2'd1);
        tick();
        chk("bp_first", 32'(fif.data), 32'h6);
        fif.ready = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("bp_hold_valid_%0d", i), 32'(fif.valid), 1);
            chk($sformatf("bp_hold_data_%0d", i), 32'(fif.data), 32'h6);
            chk($sformatf("bp_hold_idx_%0d", i), 32'(fif.idx), 0);
            chk($sformatf("bp_hold_seed_%0d", i), 32'(seed), 32'h6);
        end
        fif.ready = 1;
        tick();
        chk("bp_data1", 32'(fif.data), 32'h7);
        chk("bp_idx1", 32'(fif.idx), 1);
        tick();
        chk("bp_data2", 32'(fif.data), 32'h8);
        chk("bp_idx2", 32'(fif.idx), 2);
        tick();
        chk("bp_drained", 32'(fif.valid), 0);
        tick();
        chk("bp_done", 32'(done), 1);
        chk("bp_seed", 32'(seed), 32'h8);

        // zero-seed load plus zero-frame run
        begin_run(1'b1, 28'h0, 8'd0, 2'd2);
        chk("z_seed", 32'(seed), 32'hACE1);
        chk("z_busy", 32'(busy), 0);
        chk("z_valid", 32'(fif.valid), 0);
        chk("z_done_early", 32'(done), 0);
        tick();
        chk("z_done", 32'(done), 1);
        chk("z_busy2", 32'(busy), 0);
        chk("z_valid2", 32'(fif.valid), 0);
        tick();
        chk("z_done_pulse", 32'(done), 0);

        // start/seed_load/num_frames/probability changes during RUN are ignored
        begin_run(1'b1, 28'h10, 8'd4, 2'd2);
        tick();
        chk("ig_data0", 32'(fif.data), 32'h11);
        start = 1; seed_load = 1; seed_in = 28'h99; num_frames = 8'd1; probability_in = 2'd0;
        tick();
        chk("ig_data1", 32'(fif.data), 32'h12);
        chk("ig_idx1", 32'(fif.idx), 1);
        chk("ig_prob", 32'(probability), 2);
        start = 0; seed_load = 0;
        tick();
        chk("ig_data2", 32'(fif.data), 32'h13);
        chk("ig_busy", 32'(busy), 1);
        tick();
        chk("ig_data3", 32'(fif.data), 32'h14);
        chk("ig_idx3", 32'(fif.idx), 3);
        tick();
        chk("ig_drained", 32'(fif.valid), 0);
        tick();
        chk("ig_done", 32'(done), 1);
        chk("ig_seed", 32'(seed), 32'h14);

        // asynchronous reset mid-run aborts without a done pulse
        begin_run(1'b1, 28'h5, 8'd10, 2'd3);
        tick();
        tick();
        chk("ar_pre_data", 32'(fif.data), 32'h7);
        #2 rst = 1;
        #1;
        chk("ar_seed",  32'(seed), 32'hACE1);
        chk("ar_valid", 32'(fif.valid), 0);
        chk("ar_data",  32'(fif.data), 0);
        chk("ar_idx",   32'(fif.idx), 0);
        chk("ar_busy",  32'(busy), 0);
        chk("ar_prob",  32'(probability), 0);
        tick();
        chk("ar_no_done", 32'(done), 0);
        #2 rst = 0;
        tick();
        chk("ar_no_done2", 32'(done), 0);
        begin_run(1'b0, 28'h0, 8'd1, 2'd1);
        tick();
        chk("ar_next_data", 32'(fif.data), 32'hACE2);
        chk("ar_next_idx", 32'(fif.idx), 0);
        tick();
        tick();
        chk("ar_next_done", 32'(done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lfsr_seed_sequencer.md
Name: lfsr_seed_sequencer

Overview:
- Sequential upstream/downstream partner of the combinational LFSR probability stage.
- Owns the seed state register and drives seed and probability into the comb stage.
- Captures the comb stage's rnd word each step and feeds it back as the next seed.
- Emits one rnd word per frame to the segment-display logic over a valid/ready handshake, for a programmed number of frames.

Parameters:
RNDSIZE, 8, random-size constant; word width W = RNDSIZE*(RNDSIZE-1)/2 (28 at default); W >= 16 required
SEED_DEFAULT, 28'h000_ACE1 (zero-extended/truncated to W), seed used after reset and on zero-seed load

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
seed_in  input  W  externally supplied seed
seed_load  input  1  load seed_in into the state register (IDLE only)
start  input  1  begin a run (IDLE only)
num_frames  input  8  number of frames in the run, latched at start
probability_in  input  2  probability code, latched at start
seed  output  W  current state register, to comb-stage seed input
probability  output  2  latched probability code, to comb stage
rnd_in  input  W  comb-stage rnd output
frame_valid  output  1  frame_data/frame_idx valid
frame_ready  input  1  consumer accepts the frame
frame_data  output  W  captured rnd word
frame_idx  output  8  index of frame_data, 0..num_frames-1
busy  output  1  high in RUN or DRAIN
done  output  1  one-cycle pulse at run completion

Behaviour:
- Reset (async assert, sync-release safe): state=IDLE; seed=SEED_DEFAULT; probability=0; frame_valid=0; frame_data=0; frame_idx=0; busy=0; done=0; internal counters=0. Reset mid-run aborts the run; no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - seed_load=1 loads seed<=seed_in, or SEED_DEFAULT if seed_in==0.
  - start=1 latches num_frames and probability_in.
  - start with num_frames!=0 -> RUN.
  - start with num_frames==0 -> DONE (no frames).
  - seed_load and start in the same cycle: the load takes effect first; the run uses the new seed from its first step.
- RUN: a step occurs on any edge where (frame_valid==0 || frame_ready==1).
  - Step actions: frame_data<=rnd_in; seed<=rnd_in; frame_idx<=issue count; frame_valid<=1; issue count++.
  - When the issue count reaches num_frames after a step -> DRAIN.
  - No step while frame_valid=1 and frame_ready=0. seed, frame_data and frame_idx are held stable.
- DRAIN: frame_valid is held until frame_ready=1. On that edge: frame_valid<=0 and -> DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- Ignored inputs: seed_load and start are ignored outside IDLE. Changes to probability_in mid-run have no effect.
- Latency:
  - start sampled at edge E0 -> RUN.
  - First step at E1, so frame_valid is high after E1.
  - With frame_ready tied high: one frame per cycle, last frame visible after E(num_frames), done high after E(num_frames+2).
- Handshake rules: valid never drops without ready; data and idx stable while valid && !ready; no combinational path from frame_ready to frame_valid.
- Width rules: num_frames=255 is legal. The issue counter is 8 bit and compares with equality, so no wrap occurs. frame_idx wraps never.
- busy = (state==RUN || state==DRAIN).
- The seed register persists across runs: a new run continues the sequence unless seed_load is used.

Decomposition:
- Shared package/include:
  - W derivation from RNDSIZE (same macro as the comb stage).
  - FSM state encoding constants (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3).
  - SEED_DEFAULT.
- Sub-module frame_out_reg: single-entry valid/ready output register (data+idx), reused by other frame producers.
- The comb LFSR stage is instantiated by the parent, not inside this block.

Test Plan:
- Bench stub rnd_in = seed+1. Reset; seed_load seed_in=28'h5 then start num_frames=3, ready=1 -> frames 6,7,8 with idx 0,1,2 on consecutive cycles; done one cycle after last accept; seed=8 at end.
- Same run with frame_ready low for 4 cycles after first frame -> frame_data=6, idx=0 held all 4 cycles; no seed advance; sequence resumes 7,8; no frame lost or duplicated.
- seed_load seed_in=0 -> seed=SEED_DEFAULT; start num_frames=0 -> no frame_valid, done pulse after 2 cycles, busy never high.
- start num_frames=255, ready=1 -> 255 frames, idx 0..254, last data = seed_start+255, done pulse once.
- Assert rst during RUN after 2 frames -> all outputs at reset values immediately (async), no done. Next run starts from SEED_DEFAULT.
- start and seed_load pulsed during RUN -> ignored: latched num_frames, probability and sequence unchanged.
